// File: rtl/out_port_arbiter.sv
// out_port_arbiter
// Per-output-FIFO arbiter. Picks one requesting input port round-robin, holds the grant for a
// whole packet, and forwards the granted port's words into the output FIFO write side through a
// single register stage. A packet is only granted when the FIFO can absorb a maximum-size packet.
// A watchdog releases a grant whose port stops sending.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus_sel             per-input-port request (level, held until packet done)
//   in_valid, in_eop    per-input-port word valid / end-of-packet (eop qualified by valid)
//   in_data             flattened input words, port x at [x*DATA_W +: DATA_W]
//   fifo_free           free words in output FIFO (sampled only while idle)
//   fifo_full           output FIFO full
//   grant, grant_idx    one-hot and binary grant; busy marks a packet in progress
//   fifo_wr_en/_wdata/_wr_eop  registered FIFO write
//   err_timeout         1-cycle pulse on watchdog release
//   err_ovf             1-cycle pulse when a granted word is dropped because the FIFO is full
module out_port_arbiter #(
  parameter int unsigned PORT_NUM      = 16,
  parameter int unsigned PTR_W         = 4,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned FREE_W        = 10,
  parameter int unsigned MAX_PKT_WORDS = 256,
  parameter int unsigned TIMEOUT       = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORT_NUM-1:0]        bus_sel,
  input  logic [PORT_NUM-1:0]        in_valid,
  input  logic [PORT_NUM-1:0]        in_eop,
  input  logic [PORT_NUM*DATA_W-1:0] in_data,
  input  logic [FREE_W-1:0]          fifo_free,
  input  logic                       fifo_full,
  output logic [PORT_NUM-1:0]        grant,
  output logic [PTR_W-1:0]           grant_idx,
  output logic                       busy,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wdata,
  output logic                       fifo_wr_eop,
  output logic                       err_timeout,
  output logic                       err_ovf
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    grant_idx_q, grant_idx_d;
  logic [WdogW-1:0]    wdog_q, wdog_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_eop_q, wr_eop_d;
  logic                timeout_q, timeout_d;
  logic                ovf_q, ovf_d;

  logic [PTR_W-1:0]    scan_idx;
  logic [PTR_W-1:0]    winner;
  logic [PTR_W-1:0]    next_ptr;
  logic                sel_valid;
  logic                sel_eop;
  logic [DATA_W-1:0]   sel_data;

  // Round-robin pick: scan from rr_ptr upward; iterating from the far end lets the nearest
  // requester overwrite. Index arithmetic wraps because PORT_NUM == 2**PTR_W.
  always_comb begin
    winner   = rr_ptr_q;
    scan_idx = rr_ptr_q;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      scan_idx = rr_ptr_q + PTR_W'(i);
      if (bus_sel[scan_idx]) begin
        winner = scan_idx;
      end
    end
  end

  assign sel_valid = in_valid[grant_idx_q];
  assign sel_eop   = in_eop[grant_idx_q];
  assign sel_data  = in_data[grant_idx_q*DATA_W +: DATA_W];
  assign next_ptr  = grant_idx_q + PTR_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    wdog_d      = wdog_q;
    wr_en_d     = 1'b0;
    wdata_d     = wdata_q;
    wr_eop_d    = 1'b0;
    timeout_d   = 1'b0;
    ovf_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((|bus_sel) && (fifo_free >= FREE_W'(MAX_PKT_WORDS))) begin
          grant_idx_d = winner;
          wdog_d      = '0;
          state_d     = StXfer;
        end
      end
      StXfer: begin
        if (sel_valid) begin
          wdog_d = '0;
          if (!fifo_full) begin
            wr_en_d  = 1'b1;
            wdata_d  = sel_data;
            wr_eop_d = sel_eop;
          end else begin
            ovf_d = 1'b1;
          end
          // A dropped EOP still closes the packet.
          if (sel_eop) begin
            state_d  = StIdle;
            rr_ptr_d = next_ptr;
          end
        end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th silent cycle: release and skip the stalled port.
          timeout_d = 1'b1;
          wdog_d    = '0;
          state_d   = StIdle;
          rr_ptr_d  = next_ptr;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      wdog_q      <= '0;
      wr_en_q     <= 1'b0;
      wdata_q     <= '0;
      wr_eop_q    <= 1'b0;
      timeout_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      wdog_q      <= wdog_d;
      wr_en_q     <= wr_en_d;
      wdata_q     <= wdata_d;
      wr_eop_q    <= wr_eop_d;
      timeout_q   <= timeout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy        = (state_q == StXfer);
  assign grant       = busy ? ({{(PORT_NUM-1){1'b0}}, 1'b1} << grant_idx_q) : '0;
  assign grant_idx   = grant_idx_q;
  assign fifo_wr_en  = wr_en_q;
  assign fifo_wdata  = wdata_q;
  assign fifo_wr_eop = wr_eop_q;
  assign err_timeout = timeout_q;
  assign err_ovf     = ovf_q;

endmodule

// File: doc/out_port_arbiter.md
Name: out_port_arbiter

Overview:
- One instance per output FIFO, fed by that FIFO's transposed request vector fifo_N_bus_sel from the bus-select interconnect; bit x = input port x requests this output.
- Arbitrates round-robin among requesting input ports and holds the grant for a whole packet.
- Muxes the granted port's data into the output FIFO write side.
- Guards FIFO space at grant time, with a stall watchdog and overflow flag.

Parameters:
- PORT_NUM, 16, number of input ports (request vector width)
- PTR_W, 4, log2(PORT_NUM), width of grant index and round-robin pointer
- DATA_W, 32, data word width per input port
- FREE_W, 10, width of FIFO free-word count
- MAX_PKT_WORDS, 256, maximum packet length in words; required free space before granting
- TIMEOUT, 1023, idle cycles allowed inside a granted packet before forced release (counter width 10)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- bus_sel  input  PORT_NUM  per-input-port request to this output; level, held until packet done
- in_valid  input  PORT_NUM  per-input-port data word valid
- in_eop  input  PORT_NUM  per-input-port end-of-packet, qualified by in_valid
- in_data  input  PORT_NUM*DATA_W  flattened input words; port x occupies [x*DATA_W +: DATA_W]
- fifo_free  input  FREE_W  free words in output FIFO
- fifo_full  input  1  output FIFO full
- grant  output  PORT_NUM  one-hot grant to input ports; all zero when idle
- grant_idx  output  PTR_W  binary index of granted port; valid when busy=1
- busy  output  1  packet transfer in progress
- fifo_wr_en  output  1  FIFO write strobe
- fifo_wdata  output  DATA_W  FIFO write data
- fifo_wr_eop  output  1  EOP marker written with fifo_wdata
- err_timeout  output  1  1-cycle pulse on watchdog release
- err_ovf  output  1  1-cycle pulse when a valid word is dropped because fifo_full

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=0; watchdog=0.
  - Outputs grant, grant_idx, busy, fifo_wr_en, fifo_wdata, fifo_wr_eop, err_timeout and err_ovf are all 0.
  - Reset mid-packet abandons the packet immediately; no EOP is written.
- FSM states: IDLE, XFER.
- IDLE:
  - Stay in IDLE if bus_sel==0 or fifo_free < MAX_PKT_WORDS.
  - Otherwise select the first set bit of bus_sel scanning rr_ptr, rr_ptr+1, ... mod PORT_NUM.
  - Next cycle: grant one-hot, grant_idx = winner, busy=1, state=XFER.
  - Request-to-grant latency is exactly 1 cycle.
- XFER:
  - grant, grant_idx and busy are held constant. Later bus_sel changes are ignored, including deassertion of the granted bit.
  - Each cycle with in_valid[grant_idx]=1 and fifo_full=0: next cycle fifo_wr_en=1, fifo_wdata=in_data word of grant_idx, fifo_wr_eop=in_eop[grant_idx]. Write path latency is 1 cycle, registered.
  - in_valid on non-granted ports is ignored.
  - in_valid[grant_idx]=1 with fifo_full=1: word dropped, fifo_wr_en=0, err_ovf pulses next cycle. If that word carried EOP, the packet still ends.
  - in_valid[grant_idx] & in_eop[grant_idx] (written or dropped): next cycle grant=0, busy=0, rr_ptr=(grant_idx+1) mod PORT_NUM, state=IDLE.
  - The minimum gap between consecutive grants is therefore 1 idle cycle.
- Watchdog:
  - Counts XFER cycles with in_valid[grant_idx]=0; cleared by any granted valid word and on entry to XFER.
  - On reaching TIMEOUT: next cycle err_timeout pulses, grant released and state=IDLE.
  - No EOP is written; rr_ptr advances past the stalled port.
- Simultaneous events: EOP and watchdog expiry in the same cycle resolve as normal EOP, with no err_timeout.
- Pointer wrap: grant_idx=PORT_NUM-1 gives rr_ptr=0.
- fifo_free is sampled only in IDLE; upstream guarantees packets of at most MAX_PKT_WORDS words.
- Invariants checked by assertions:
  - grant is zero or one-hot.
  - busy == |grant.
  - fifo_wr_en implies busy was 1 in the previous cycle.

Test Plan:
- Single request: bus_sel=0x0004, fifo_free=512, port 2 sends 3 words A,B,C with EOP on C -> grant=0x0004 one cycle after request; fifo_wr_en writes A,B,C each 1 cycle after input; fifo_wr_eop only on C; busy drops the cycle after C; next rr_ptr=3.
- Round-robin fairness: bus_sel=0x8001 held, 1-word packets -> grants alternate 0x0001, 0x8000, 0x0001; wrap from port 15 to 0 verified.
- Space gating: bus_sel=0x0010 with fifo_free=255 -> no grant for 20 cycles; raise fifo_free to 256 -> grant=0x0010 next cycle.
- Overflow: mid-packet fifo_full=1 while port 2 presents word X -> X not written, err_ovf one 1-cycle pulse, grant held; next word written after fifo_full=0.
- Watchdog: granted port 5 goes silent after 1 word -> err_timeout pulses exactly 1023 idle cycles later; grant=0; rr_ptr=6; no EOP written.
- Reset mid-XFER: assert rst_n=0 during a 10-word packet -> all outputs 0 asynchronously; after release, first grant follows rr_ptr=0 ordering.
